// File: rtl/cfi_pkg.sv
// Shared CFI types: the per-port log record, its flag set, the optional
// queue statistics record and a popcount helper for commit-port vectors.
package cfi_pkg;

  localparam int unsigned CFI_NR_COMMIT_PORTS = 2;
  localparam int unsigned CFI_LOG_QUEUE_DEPTH = 8;

  typedef struct packed {
    logic is_call;
    logic is_ret;
    logic is_jump;
    logic is_branch;
  } cfi_flags_t;

  typedef struct packed {
    logic [31:0] addr_pc;
    logic [31:0] addr_target;
    cfi_flags_t  flags;
  } cfi_log_t;

  typedef struct packed {
    logic [31:0] pushed;
    logic [31:0] dropped;
    logic [31:0] halt_cycles;
    logic [31:0] max_occupancy;
  } cfi_queue_stats_t;

  // Number of set bits in a commit-port-wide vector.
  function automatic int unsigned popcount(input logic [CFI_NR_COMMIT_PORTS-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < int'(CFI_NR_COMMIT_PORTS); i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/cfi_log_compact.sv
// Combinational compactor: moves the logs of requesting ports to the low
// slots in port order, so the queue can write them to consecutive entries.
module cfi_log_compact
  import cfi_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = CFI_NR_COMMIT_PORTS,
  parameter int unsigned CNT_W           = 4
) (
  input  logic [NR_COMMIT_PORTS-1:0] req,
  input  cfi_log_t                   logs         [NR_COMMIT_PORTS],
  output cfi_log_t                   packed_log   [NR_COMMIT_PORTS],
  output logic [NR_COMMIT_PORTS-1:0] packed_valid,
  output logic [CNT_W-1:0]           n_push
);

  localparam int unsigned IW = (NR_COMMIT_PORTS > 1) ? $clog2(NR_COMMIT_PORTS) : 1;

  logic [IW-1:0] idx;

  // Walk ports lowest-first, placing each requester in the next free slot.
  always_comb begin
    // NOTE: every output gets a default before the loop; a path that skips an assignment would otherwise infer a latch.
    packed_log   = '{default: '0};
    packed_valid = '0;
    idx          = '0;
    for (int i = 0; i < int'(NR_COMMIT_PORTS); i++) begin
      if (req[i]) begin
        packed_log[idx]   = logs[i];
        packed_valid[idx] = 1'b1;
        idx               = idx + IW'(1);
      end
    end
  end

  assign n_push = CNT_W'(popcount(req));

endmodule

// File: rtl/cfi_log_queue.sv
// CFI log queue: captures retiring, filter-selected commit logs into a
// circular FIFO and drains them one per cycle to the CFI checker.
// Optional statistics output is enabled by defining CFI_LOG_QUEUE_STATS_EN.
module cfi_log_queue
  import cfi_pkg::*;
#(
  parameter  int unsigned NR_COMMIT_PORTS = CFI_NR_COMMIT_PORTS,
  parameter  int unsigned DEPTH           = CFI_LOG_QUEUE_DEPTH,
  localparam int unsigned CNT_W           = $clog2(DEPTH) + 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  cfi_log_t                   log_i        [NR_COMMIT_PORTS],
  input  logic [NR_COMMIT_PORTS-1:0] cfi_i,
  input  logic [NR_COMMIT_PORTS-1:0] commit_ack_i,
  output logic                       halt_o,
  output cfi_log_t                   log_o,
  output logic                       log_valid_o,
  input  logic                       log_ready_i,
  output logic                       overflow_o,
  output logic [CNT_W-1:0]           count_o
`ifdef CFI_LOG_QUEUE_STATS_EN
  ,
  output cfi_queue_stats_t           stats_o
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [CNT_W-1:0]           count;
  logic                       overflow;
  cfi_log_t                   storage      [DEPTH];

  logic [NR_COMMIT_PORTS-1:0] req;
  cfi_log_t                   packed_log   [NR_COMMIT_PORTS];
  logic [NR_COMMIT_PORTS-1:0] packed_valid;
  logic [NR_COMMIT_PORTS-1:0] wr_en;
  logic [CNT_W-1:0]           n_push;
  logic [CNT_W-1:0]           n_acc;
  logic [CNT_W-1:0]           free;
  logic                       drop;
  logic                       pop;

  assign req = cfi_i & commit_ack_i;

  cfi_log_compact #(
    .NR_COMMIT_PORTS (NR_COMMIT_PORTS),
    .CNT_W           (CNT_W)
  ) u_compact (
    .req          (req),
    .logs         (log_i),
    .packed_log   (packed_log),
    .packed_valid (packed_valid),
    .n_push       (n_push)
  );

  // Free space from the registered count only; a same-cycle pop is not credited.
  assign free  = CNT_W'(DEPTH) - count;
  assign drop  = n_push > free;
  assign n_acc = drop ? free : n_push;
  assign pop   = log_valid_o & log_ready_i;

  // Only the first 'free' packed slots may be written this cycle.
  always_comb begin
    wr_en = '0;
    for (int j = 0; j < int'(NR_COMMIT_PORTS); j++) begin
      wr_en[j] = packed_valid[j] && (CNT_W'(j) < free);
    end
  end

  // Pointer, occupancy and sticky overflow state; flush wins over push and pop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(n_acc);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count + n_acc - CNT_W'(pop);
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Entry storage: accepted packed logs land at consecutive slots from wr_ptr.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: storage is reset so log_o reads zero out of reset; flush leaves contents alone since count gates validity.
    if (rst_i) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        storage[k] <= '0;
      end
    end else if (!flush_i) begin
      for (int j = 0; j < int'(NR_COMMIT_PORTS); j++) begin
        if (wr_en[j]) begin
          storage[wr_ptr + PTR_W'(j)] <= packed_log[j];
        end
      end
    end
  end

  assign log_valid_o = (count != '0);
  assign log_o       = storage[rd_ptr];
  assign halt_o      = free < CNT_W'(NR_COMMIT_PORTS);
  assign overflow_o  = overflow;
  assign count_o     = count;

`ifdef CFI_LOG_QUEUE_STATS_EN
  cfi_queue_stats_t stats;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Saturating statistics; survive flush, cleared only by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stats <= '0;
    end else begin
      if (!flush_i) begin
        stats.pushed  <= sat_add(stats.pushed, 32'(n_acc));
        stats.dropped <= sat_add(stats.dropped, 32'(n_push - n_acc));
      end
      stats.halt_cycles <= sat_add(stats.halt_cycles, 32'(halt_o));
      if (32'(count) > stats.max_occupancy) begin
        stats.max_occupancy <= 32'(count);
      end
    end
  end

  assign stats_o = stats;
`endif

endmodule

// File: tb/tb_cfi_log_queue.sv
// Self-checking bench for cfi_log_queue: a queue scoreboard of expected logs
// plus a small occupancy/overflow model, checked every cycle.
module tb_cfi_log_queue;
  import cfi_pkg::*;

  localparam int NR    = CFI_NR_COMMIT_PORTS;
  localparam int DEPTH = CFI_LOG_QUEUE_DEPTH;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              flush_i;
  cfi_log_t          log_i [NR];
  logic [NR-1:0]     cfi_i;
  logic [NR-1:0]     commit_ack_i;
  logic              halt_o;
  cfi_log_t          log_o;
  logic              log_valid_o;
  logic              log_ready_i;
  logic              overflow_o;
  logic [CNT_W-1:0]  count_o;
`ifdef CFI_LOG_QUEUE_STATS_EN
  cfi_queue_stats_t  stats_o;
`endif

  cfi_log_queue dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .log_i        (log_i),
    .cfi_i        (cfi_i),
    .commit_ack_i (commit_ack_i),
    .halt_o       (halt_o),
    .log_o        (log_o),
    .log_valid_o  (log_valid_o),
    .log_ready_i  (log_ready_i),
    .overflow_o   (overflow_o),
    .count_o      (count_o)
`ifdef CFI_LOG_QUEUE_STATS_EN
    ,
    .stats_o      (stats_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int          n_checks = 0;
  int          n_fail   = 0;
  cfi_log_t    sb[$];
  int          m_count  = 0;
  logic        m_ovf    = 1'b0;
  logic [31:0] next_pc  = 32'h8000_0000;

  function automatic cfi_log_t make_log(input logic [31:0] pc);
    cfi_log_t l;
    l.addr_pc     = pc;
    l.addr_target = pc + 32'h0000_0100;
    l.flags       = cfi_flags_t'(pc[5:2]);
    return l;
  endfunction

  // One clock: check model state, drive inputs, update scoreboard, advance.
  task automatic cycle(input logic [NR-1:0] cfi, input logic [NR-1:0] ack,
                       input logic rdy, input logic fl);
    logic [NR-1:0] req;
    int            free;
    int            acc;
    bit            pop;
    cfi_log_t      exp;
    logic          exp_halt;

    exp_halt = ((DEPTH - m_count) < NR);
    n_checks++;
    if (count_o !== CNT_W'(m_count)) begin
      n_fail++;
      $display("FAIL count: got %0d expected %0d", count_o, m_count);
    end
    n_checks++;
    if (log_valid_o !== (m_count != 0)) begin
      n_fail++;
      $display("FAIL log_valid: got %0b expected %0b", log_valid_o, m_count != 0);
    end
    n_checks++;
    if (halt_o !== exp_halt) begin
      n_fail++;
      $display("FAIL halt: got %0b expected %0b (count %0d)", halt_o, exp_halt, m_count);
    end
    n_checks++;
    if (overflow_o !== m_ovf) begin
      n_fail++;
      $display("FAIL overflow: got %0b expected %0b", overflow_o, m_ovf);
    end

    for (int i = 0; i < NR; i++) begin
      log_i[i] = make_log(next_pc);
      next_pc  = next_pc + 32'd4;
    end
    cfi_i        = cfi;
    commit_ack_i = ack;
    log_ready_i  = rdy;
    flush_i      = fl;
    req          = cfi & ack;

    if (fl) begin
      sb.delete();
      m_count = 0;
      m_ovf   = 1'b0;
    end else begin
      pop = rdy && (m_count != 0);
      if (pop) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard: pop with no expected entry");
        end else begin
          exp = sb.pop_front();
          if (log_o !== exp) begin
            n_fail++;
            $display("FAIL head_log: got %h expected %h", log_o, exp);
          end
        end
      end
      free = DEPTH - m_count;
      acc  = 0;
      for (int i = 0; i < NR; i++) begin
        if (req[i]) begin
          if (free > 0) begin
            sb.push_back(log_i[i]);
            free--;
            acc++;
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
      m_count = m_count + acc - (pop ? 1 : 0);
    end

    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i        = 1'b1;
    flush_i      = 1'b0;
    cfi_i        = '0;
    commit_ack_i = '0;
    log_ready_i  = 1'b0;
    for (int i = 0; i < NR; i++) log_i[i] = '0;
    repeat (2) @(posedge clk_i);
    #1;
    n_checks++;
    if (log_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", log_valid_o); end
    n_checks++;
    if (halt_o !== 1'b0) begin n_fail++; $display("FAIL reset_halt: got %0b expected 0", halt_o); end
    n_checks++;
    if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %0b expected 0", overflow_o); end
    n_checks++;
    if (count_o !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count_o); end
    n_checks++;
    if (log_o !== '0) begin n_fail++; $display("FAIL reset_log: got %h expected 0", log_o); end
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_single_port1();
    next_pc = 32'h8000_000C;  // port 1 sees 0x8000_0010
    cycle(2'b10, 2'b10, 1'b0, 1'b0);
    n_checks++;
    if (count_o !== CNT_W'(1)) begin n_fail++; $display("FAIL single_count: got %0d expected 1", count_o); end
    n_checks++;
    if (log_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0b expected 1", log_valid_o); end
    n_checks++;
    if (log_o.addr_pc !== 32'h8000_0010) begin
      n_fail++; $display("FAIL single_pc: got %h expected 80000010", log_o.addr_pc);
    end
    cycle(2'b00, 2'b00, 1'b0, 1'b1);
  endtask

  task automatic test_gating();
    cycle(2'b01, 2'b10, 1'b0, 1'b0);
    n_checks++;
    if (count_o !== '0) begin n_fail++; $display("FAIL gating_none: got %0d expected 0", count_o); end
    cycle(2'b11, 2'b10, 1'b0, 1'b0);
    n_checks++;
    if (count_o !== CNT_W'(1)) begin n_fail++; $display("FAIL gating_one: got %0d expected 1", count_o); end
    cycle(2'b00, 2'b00, 1'b1, 1'b0);
  endtask

  task automatic test_fill_halt_overflow();
    repeat (3) cycle(2'b11, 2'b11, 1'b0, 1'b0);
    n_checks++;
    if (count_o !== CNT_W'(6)) begin n_fail++; $display("FAIL fill_count6: got %0d expected 6", count_o); end
    n_checks++;
    if (halt_o !== 1'b0) begin n_fail++; $display("FAIL halt_at6: got %0b expected 0", halt_o); end
    cycle(2'b01, 2'b01, 1'b0, 1'b0);
    n_checks++;
    if (halt_o !== 1'b1) begin n_fail++; $display("FAIL halt_at7: got %0b expected 1", halt_o); end
    cycle(2'b11, 2'b11, 1'b0, 1'b0);
    n_checks++;
    if (count_o !== CNT_W'(8)) begin n_fail++; $display("FAIL full_count: got %0d expected 8", count_o); end
    n_checks++;
    if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL overflow_set: got %0b expected 1", overflow_o); end
    repeat (DEPTH) cycle(2'b00, 2'b00, 1'b1, 1'b0);
    n_checks++;
    if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky: got %0b expected 1", overflow_o); end
    cycle(2'b00, 2'b00, 1'b0, 1'b1);
    n_checks++;
    if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL overflow_flush: got %0b expected 0", overflow_o); end
  endtask

  task automatic test_steady_wrap();
    for (int n = 0; n < 20; n++) begin
      cycle(2'b01, 2'b01, 1'b1, 1'b0);
      n_checks++;
      if (count_o !== CNT_W'(1)) begin n_fail++; $display("FAIL steady_count[%0d]: got %0d expected 1", n, count_o); end
    end
    cycle(2'b00, 2'b00, 1'b1, 1'b0);
  endtask

  task automatic test_flush_same_cycle();
    repeat (5) cycle(2'b11, 2'b11, 1'b0, 1'b0);
    cycle(2'b11, 2'b11, 1'b1, 1'b1);
    n_checks++;
    if (count_o !== '0) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", count_o); end
    n_checks++;
    if (log_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %0b expected 0", log_valid_o); end
    n_checks++;
    if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL flush_overflow: got %0b expected 0", overflow_o); end
    cycle(2'b00, 2'b00, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 300; n++) begin
      cycle(NR'($urandom), NR'($urandom), 1'($urandom), ($urandom_range(0, 63) == 0));
    end
    for (int n = 0; n < DEPTH + 2 && m_count != 0; n++) begin
      cycle(2'b00, 2'b00, 1'b1, 1'b0);
    end
    n_checks++;
    if (count_o !== '0) begin n_fail++; $display("FAIL drain_count: got %0d expected 0", count_o); end
  endtask

  initial begin
    test_reset();
    test_single_port1();
    test_gating();
    test_fill_halt_overflow();
    test_steady_wrap();
    test_flush_same_cycle();
    test_back_to_back();
    cycle(2'b00, 2'b00, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
